adma_desc_fetch: RTL
====================

# adma_desc_fetch

Descriptor fetch stage directly upstream of the DMA engine. Walks an ADMA2-style descriptor table in system RAM one byte at a time, assembles each 96-bit descriptor, and resolves NOP and LINK entries internally. Presents only TRAN descriptors to the DMA on its 96-bit command port (`addr_in_COM` format). Reports completion on the END descriptor and flags malformed tables or excessive link chains as errors.

## Interface
Parameters:
- `MAX_LINKS`, 4: consecutive LINK descriptors tolerated before a link-loop error.
- `DESC_BYTES`, 12: bytes per descriptor; fixed, not to be overridden.

Ports:
- `clk_in_COM` in 1: single clock; all logic on rising edge.
- `reset_in_COM` in 1: **asynchronous, active-high** reset.
- `start_REG` in 1: one-cycle pulse; begins the walk at `desc_base_REG`.
- `stop_REG` in 1: abort; has priority over every event except reset.
- `desc_base_REG` in 64: byte address of the first descriptor; sampled on `start_REG`.
- `rd_en_RAM` out 1: RAM byte read strobe.
- `addr_out_RAM` out 64: RAM byte address, valid while `rd_en_RAM` is high.
- `data_in_RAM` in 8: read data; valid exactly 1 cycle after `rd_en_RAM`.
- `desc_out_COM` out 96: assembled descriptor to the DMA, in `addr_in_COM` layout.
- `desc_valid_COM` out 1: `desc_out_COM` holds a TRAN descriptor.
- `desc_ack_COM` in 1: DMA accepts the descriptor.
- `error_in_COM` in 1: DMA-side error; aborts the walk.
- `busy_fetch` out 1: high in every state except IDLE, DONE, ERROR.
- `done` out 1: level; table completed.
- `error` out 1: level; walk aborted on error.
- `error_addr` out 64: base address of the descriptor being processed when `error` is set.

## Operation
Descriptor decode, with byte k of the descriptor at `cur_addr+k` and little-endian assembly (byte 0 → bits 7:0):
- bit 0 valid; bit 1 end; bits 5:4 act; bits 31:16 length; bits 95:32 address.
- Act decode: 00 NOP, 01 reserved (handled as NOP), 10 TRAN, 11 LINK.

States:
- **IDLE**: all strobes low. `start_REG` sets `cur_addr <= desc_base_REG`, clears `done`, `error`, and the link counter, then goes to FETCH.
- **FETCH**: issues 12 back-to-back reads at `cur_addr+0`…`cur_addr+11`, one per cycle. A byte counter (0..11) captures returning data into a 96-bit shift/assembly register. After the 12th read, goes to LAST.
- **LAST**: captures byte 11, then goes to DECODE.
- **DECODE**, one cycle:
  - valid=0 → ERROR.
  - LINK → `cur_addr <= desc[95:32]`, link counter +1. If the counter reaches `MAX_LINKS` → ERROR. Otherwise, if end=1 → DONE; else → FETCH.
  - TRAN → link counter cleared, go to PRESENT.
  - NOP or reserved → link counter cleared. If end=1 → DONE; else `cur_addr += 12` and → FETCH.
- **PRESENT**: `desc_valid_COM` is high and `desc_out_COM` is stable. When `desc_valid_COM` and `desc_ack_COM` are both high in the same cycle, the transfer occurs. If end=1 → DONE; else `cur_addr += 12` and → FETCH.
- **DONE**: `done` is high. `start_REG` restarts the walk.
- **ERROR**: `error` is high and `error_addr` is set to the `cur_addr` of the failing descriptor. `start_REG` restarts the walk.

Rules:
- `stop_REG` in any busy state → IDLE next cycle. `rd_en_RAM` and `desc_valid_COM` drop immediately. An in-flight read byte is discarded. `done` and `error` are not set.
- `error_in_COM` in any busy state → ERROR with the current `cur_addr`. If `stop_REG` is asserted in the same cycle, `stop_REG` wins.
- `start_REG` while busy is ignored.
- Address arithmetic is 64-bit modulo 2^64; wrap-around is legal and silent.
- Length 0 in a TRAN descriptor is passed through unchanged; interpreting it is the DMA's job.

## Timing
- All outputs reset to 0. State resets to IDLE.
- `start_REG` at cycle 0 → first `rd_en_RAM` at cycle 1. Reads occupy cycles 1–12; byte 11 is captured at cycle 13; DECODE runs at cycle 14.
- For a TRAN descriptor, `desc_valid_COM` rises at cycle 15.
- With `desc_ack_COM` high at cycle 15, the next descriptor's first read is at cycle 16. Per-descriptor overhead is 15 cycles plus the DMA wait.
- NOP or LINK descriptors cost 14 cycles each and produce no `desc_valid_COM`.
- `done` and `error` rise the cycle after the deciding DECODE or ack. They hold until the next `start_REG`.
- Reset asserted mid-walk clears every output asynchronously.

## Test plan
- Base `0x1000`; a single TRAN descriptor (valid=1, end=1, act=10, length `0x0200`, address `0xDEAD_0000`) → `desc_out_COM` = `{64'hDEAD0000,16'h0200,16'h0023}` at cycle 15. After ack, `done`=1 and `busy_fetch`=0.
- Table NOP → TRAN → TRAN(end) → exactly 2 `desc_valid_COM` handshakes. Read addresses run `0x1000`–`0x1023`, contiguous.
- LINK at `0x1000` pointing to `0x8000`, with TRAN(end) at `0x8000` → reads jump to `0x8000` after DECODE; one descriptor presented; `done`=1.
- Four consecutive LINKs (MAX_LINKS=4) → `error`=1 and `error_addr` = address of the 4th LINK. No `desc_valid_COM` ever asserted.
- Valid=0 descriptor at `0x100C` → `error`=1 and `error_addr`=`0x100C`.
- `stop_REG` at read 5 → IDLE next cycle, all outputs 0. A separate run holds `desc_ack_COM` low for 20 cycles → `desc_out_COM` stays stable throughout. Base `0xFFFF_FFFF_FFFF_FFF4` → second descriptor fetched from address 0.

Source files
------------

// File: rtl/adma_desc_fetch.sv
// ----------------------------------------------------------------------------
// adma_desc_fetch
//
// Descriptor fetch stage in front of the DMA engine. It walks an ADMA2-style
// descriptor table in system RAM one byte per cycle and assembles each
// 12-byte descriptor little-endian. NOP, reserved and LINK entries are
// resolved here. Only TRAN descriptors are presented to the DMA.
//
// Ports:
//   clk_in_COM, reset_in_COM  clock, asynchronous active-high reset
//   start_REG, stop_REG       begin a walk at desc_base_REG / abort the walk
//   desc_base_REG             byte address of the first descriptor
//   rd_en_RAM, addr_out_RAM   byte read strobe and address to RAM
//   data_in_RAM               read data, valid one cycle after rd_en_RAM
//   desc_out_COM              96-bit TRAN descriptor, qualified by desc_valid_COM
//   desc_valid_COM            descriptor offered to the DMA
//   desc_ack_COM              DMA accepts the descriptor
//   error_in_COM              DMA-side error, aborts the walk
//   busy_fetch                walk in progress
//   done, error, error_addr   completion / abort status (levels)
// ----------------------------------------------------------------------------
module adma_desc_fetch #(
    parameter int unsigned MAX_LINKS  = 4,
    parameter int unsigned DESC_BYTES = 12
) (
    input  logic        clk_in_COM,
    input  logic        reset_in_COM,
    input  logic        start_REG,
    input  logic        stop_REG,
    input  logic [63:0] desc_base_REG,
    output logic        rd_en_RAM,
    output logic [63:0] addr_out_RAM,
    input  logic [7:0]  data_in_RAM,
    output logic [95:0] desc_out_COM,
    output logic        desc_valid_COM,
    input  logic        desc_ack_COM,
    input  logic        error_in_COM,
    output logic        busy_fetch,
    output logic        done,
    output logic        error,
    output logic [63:0] error_addr
);

    localparam int unsigned LinkW      = $clog2(MAX_LINKS + 1);
    localparam logic [LinkW-1:0] LinkMax = LinkW'(MAX_LINKS);
    localparam logic [63:0] DescStride = 64'(DESC_BYTES);
    localparam logic [3:0]  LastByte   = 4'(DESC_BYTES - 1);
    localparam logic [1:0]  ActTran    = 2'b10;
    localparam logic [1:0]  ActLink    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLast,
        StDecode,
        StPresent,
        StDone,
        StError
    } state_e;

    state_e             state_q;
    logic [63:0]        cur_addr_q;
    logic [3:0]         byte_cnt_q;
    logic [95:0]        asm_q;
    logic               rd_vld_q;
    logic [LinkW-1:0]   link_cnt_q;
    logic               rd_en_q;
    logic [63:0]        addr_q;
    logic [95:0]        desc_out_q;
    logic               desc_valid_q;
    logic               done_q;
    logic               error_q;
    logic [63:0]        error_addr_q;

    logic               busy;
    logic               d_valid;
    logic               d_end;
    logic [1:0]         d_act;
    logic [63:0]        d_target;
    logic [63:0]        next_seq;
    logic [LinkW-1:0]   link_inc;

    assign busy     = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
    assign d_valid  = asm_q[0];
    assign d_end    = asm_q[1];
    assign d_act    = asm_q[5:4];
    assign d_target = asm_q[95:32];
    assign next_seq = cur_addr_q + DescStride;
    assign link_inc = link_cnt_q + LinkW'(1);

    always_ff @(posedge clk_in_COM or posedge reset_in_COM) begin
        if (reset_in_COM) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            rd_vld_q     <= 1'b0;
            link_cnt_q   <= '0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            desc_out_q   <= '0;
            desc_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_addr_q <= '0;
        end else begin
            // Read data trails the strobe by one cycle; shifting in from the top
            // leaves byte 0 in bits 7:0 after the twelfth byte.
            rd_vld_q <= rd_en_q;
            if (rd_vld_q) begin
                asm_q <= {data_in_RAM, asm_q[95:8]};
            end

            if (busy && stop_REG) begin
                state_q      <= StIdle;
                rd_en_q      <= 1'b0;
                addr_q       <= '0;
                rd_vld_q     <= 1'b0;  // drop the read still in flight
                desc_valid_q <= 1'b0;
                desc_out_q   <= '0;
            end else if (busy && error_in_COM) begin
                state_q      <= StError;
                rd_en_q      <= 1'b0;
                addr_q       <= '0;
                rd_vld_q     <= 1'b0;
                desc_valid_q <= 1'b0;
                desc_out_q   <= '0;
                error_q      <= 1'b1;
                error_addr_q <= cur_addr_q;
            end else begin
                unique case (state_q)
                    StIdle, StDone, StError: begin
                        if (start_REG) begin
                            state_q      <= StFetch;
                            cur_addr_q   <= desc_base_REG;
                            addr_q       <= desc_base_REG;
                            rd_en_q      <= 1'b1;
                            byte_cnt_q   <= '0;
                            link_cnt_q   <= '0;
                            done_q       <= 1'b0;
                            error_q      <= 1'b0;
                            error_addr_q <= '0;
                        end
                    end

                    StFetch: begin
                        if (byte_cnt_q == LastByte) begin
                            state_q <= StLast;
                            rd_en_q <= 1'b0;
                            addr_q  <= '0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 4'd1;
                            addr_q     <= addr_q + 64'd1;
                        end
                    end

                    // Waits for the last byte to land in the assembly register.
                    StLast: state_q <= StDecode;

                    StDecode: begin
                        if (!d_valid) begin
                            state_q      <= StError;
                            error_q      <= 1'b1;
                            error_addr_q <= cur_addr_q;
                        end else if (d_act == ActLink) begin
                            link_cnt_q <= link_inc;
                            if (link_inc == LinkMax) begin
                                // Report the LINK that tripped the limit, not its target.
                                state_q      <= StError;
                                error_q      <= 1'b1;
                                error_addr_q <= cur_addr_q;
                            end else begin
                                cur_addr_q <= d_target;
                                if (d_end) begin
                                    state_q <= StDone;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q    <= StFetch;
                                    addr_q     <= d_target;
                                    rd_en_q    <= 1'b1;
                                    byte_cnt_q <= '0;
                                end
                            end
                        end else if (d_act == ActTran) begin
                            link_cnt_q   <= '0;
                            state_q      <= StPresent;
                            desc_out_q   <= asm_q;
                            desc_valid_q <= 1'b1;
                        end else begin
                            // NOP and reserved act codes
                            link_cnt_q <= '0;
                            if (d_end) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                cur_addr_q <= next_seq;
                                state_q    <= StFetch;
                                addr_q     <= next_seq;
                                rd_en_q    <= 1'b1;
                                byte_cnt_q <= '0;
                            end
                        end
                    end

                    StPresent: begin
                        if (desc_ack_COM) begin
                            desc_valid_q <= 1'b0;
                            desc_out_q   <= '0;
                            if (desc_out_q[1]) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                cur_addr_q <= next_seq;
                                state_q    <= StFetch;
                                addr_q     <= next_seq;
                                rd_en_q    <= 1'b1;
                                byte_cnt_q <= '0;
                            end
                        end
                    end

                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rd_en_RAM      = rd_en_q;
    assign addr_out_RAM   = addr_q;
    assign desc_out_COM   = desc_out_q;
    assign desc_valid_COM = desc_valid_q;
    assign busy_fetch     = busy;
    assign done           = done_q;
    assign error          = error_q;
    assign error_addr     = error_addr_q;

endmodule
